// File: rtl/spi_dac_mux_tx.sv
// Write-only SPI master for multi-channel DACs: {addr, din} words are queued in a FIFO and
// shifted out MSB first under a per-channel active-low sync, with an optional LDAC strobe.
module spi_dac_mux_tx #(
  parameter int unsigned W       = 16,
  parameter int unsigned DIV     = 2,
  parameter int unsigned NCH     = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LDAC_EN = 1,
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           iocs,
  input  logic           iowr,
  input  logic [CW-1:0]  addr,
  input  logic [W-1:0]   din,
  output logic           sck,
  output logic           sdo,
  output logic [NCH-1:0] sync_n,
  output logic           ldac_n,
  output logic           busy,
  output logic           full,
  output logic           ovf
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned DCW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BCW  = $clog2(W);
  localparam int unsigned EW   = CW + W;

  typedef enum logic [1:0] {StIdle, StShift, StTrail, StGap} state_e;

  state_e          state_q;
  logic [DCW-1:0]  div_cnt_q;
  logic [BCW-1:0]  bit_cnt_q;
  logic [W-1:0]    shreg_q;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;

  logic            wr;
  logic            push;
  logic            pop;
  logic            div_last;
  logic            busy_d;
  logic [EW-1:0]   head;
  logic [CW-1:0]   head_ch;
  logic [W-1:0]    head_data;
  logic [NCH-1:0]  sync_sel;

  assign wr        = iocs & iowr;
  assign push      = wr & ~full;
  assign div_last  = (div_cnt_q == DCW'(DIV - 1));
  // Pop either from idle or straight out of the gap so back-to-back frames need no idle cycle.
  assign pop       = (count_q != '0) &&
                     ((state_q == StIdle) || ((state_q == StGap) && div_last));
  assign head      = mem_q[rd_ptr_q];
  assign head_ch   = head[EW-1:W];
  assign head_data = head[W-1:0];

  always_comb begin
    count_d = count_q + CNTW'(push) - CNTW'(pop);
  end

  // Channels at or beyond NCH leave every sync line high but the word is still shifted.
  always_comb begin
    sync_sel = '1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (head_ch == CW'(i)) sync_sel[i] = 1'b0;
    end
  end

  always_comb begin
    busy_d = pop || (state_q == StShift) || (state_q == StTrail) ||
             ((state_q == StGap) && !div_last) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {addr, din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full    <= (count_d == CNTW'(DEPTH));
      ovf     <= wr & full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sck       <= 1'b0;
      sdo       <= 1'b0;
      sync_n    <= '1;
      ldac_n    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      busy <= busy_d;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q   <= StShift;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= head_data;
            sdo       <= head_data[W-1];
            sck       <= 1'b0;
            sync_n    <= sync_sel;
          end
        end
        StShift: begin
          if (div_last) begin
            div_cnt_q <= '0;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              // Data changes on the falling edge, giving DIV cycles of setup before the rise.
              sck <= 1'b0;
              if (bit_cnt_q == BCW'(W - 1)) begin
                sdo     <= 1'b0;
                state_q <= StTrail;
              end else begin
                bit_cnt_q <= bit_cnt_q + BCW'(1);
                sdo       <= shreg_q[W-2];
                shreg_q   <= {shreg_q[W-2:0], 1'b0};
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + DCW'(1);
          end
        end
        StTrail: begin
          if (div_last) begin
            div_cnt_q <= '0;
            sync_n    <= '1;
            state_q   <= StGap;
            if ((LDAC_EN != 0) && (count_q == '0)) ldac_n <= 1'b0;
          end else begin
            div_cnt_q <= div_cnt_q + DCW'(1);
          end
        end
        StGap: begin
          if (div_last) begin
            div_cnt_q <= '0;
            ldac_n    <= 1'b1;
            if (pop) begin
              state_q   <= StShift;
              bit_cnt_q <= '0;
              shreg_q   <= head_data;
              sdo       <= head_data[W-1];
              sck       <= 1'b0;
              sync_n    <= sync_sel;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dac_mux_tx.sv
// Directed bench for spi_dac_mux_tx: a W=16/DIV=2/NCH=4 instance for frame timing, queueing,
// overflow and reset, and a W=8/DIV=1/NCH=1/no-LDAC instance for the fast and out-of-range cases.
module tb_spi_dac_mux_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_iocs, a_iowr;
  logic [1:0]  a_addr;
  logic [15:0] a_din;
  logic        a_sck, a_sdo, a_ldac, a_busy, a_full, a_ovf;
  logic [3:0]  a_sync;

  logic        b_iocs, b_iowr;
  logic [0:0]  b_addr;
  logic [7:0]  b_din;
  logic        b_sck, b_sdo, b_ldac, b_busy, b_full, b_ovf;
  logic [0:0]  b_sync;

  spi_dac_mux_tx #(.W(16), .DIV(2), .NCH(4), .DEPTH(4), .LDAC_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .iocs(a_iocs), .iowr(a_iowr), .addr(a_addr), .din(a_din),
    .sck(a_sck), .sdo(a_sdo), .sync_n(a_sync), .ldac_n(a_ldac), .busy(a_busy),
    .full(a_full), .ovf(a_ovf)
  );

  spi_dac_mux_tx #(.W(8), .DIV(1), .NCH(1), .DEPTH(4), .LDAC_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .iocs(b_iocs), .iowr(b_iowr), .addr(b_addr), .din(b_din),
    .sck(b_sck), .sdo(b_sdo), .sync_n(b_sync), .ldac_n(b_ldac), .busy(b_busy),
    .full(b_full), .ovf(b_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run observations; c is the number of clock edges since the first write edge.
  int          st_nrise, st_first_rise, st_last_rise, st_sync_low, st_nframe;
  int          st_ldac_low, st_nldac, st_first_ldac, st_first_full, st_novf, st_first_ovf;
  int          st_busy_fall, st_ntog;
  int          st_fstart [8];
  logic [3:0]  st_fsync [8];
  logic [15:0] st_word;
  logic [1:0]  wa [8];
  logic [15:0] wd [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    st_nrise = 0; st_first_rise = -1; st_last_rise = -1; st_sync_low = 0; st_nframe = 0;
    st_ldac_low = 0; st_nldac = 0; st_first_ldac = -1; st_first_full = -1; st_novf = 0;
    st_first_ovf = -1; st_busy_fall = -1; st_ntog = 0; st_word = '0;
    for (int i = 0; i < 8; i++) begin
      st_fstart[i] = -1;
      st_fsync[i]  = 4'hF;
    end
  endtask

  task automatic watch_a(input int nw, input int ncyc);
    logic ps, pl;
    logic [3:0] py;
    clear_stats();
    ps = a_sck; py = a_sync; pl = a_ldac;
    for (int c = 0; c <= ncyc; c++) begin
      if (c < nw) begin
        a_iocs = 1'b1; a_iowr = 1'b1; a_addr = wa[c]; a_din = wd[c];
      end else begin
        a_iocs = 1'b0; a_iowr = 1'b0;
      end
      tick();
      if (a_sck && !ps) begin
        if (st_first_rise < 0) st_first_rise = c;
        st_last_rise = c;
        st_nrise++;
        st_word = {st_word[14:0], a_sdo};
      end
      if (a_sync != 4'hF) begin
        st_sync_low++;
        if (py == 4'hF) begin
          if (st_nframe < 8) begin
            st_fstart[st_nframe] = c;
            st_fsync[st_nframe]  = a_sync;
          end
          st_nframe++;
        end
      end
      if (!a_ldac) begin
        st_ldac_low++;
        if (pl) begin
          st_nldac++;
          if (st_first_ldac < 0) st_first_ldac = c;
        end
      end
      if (a_full && st_first_full < 0) st_first_full = c;
      if (a_ovf) begin
        st_novf++;
        if (st_first_ovf < 0) st_first_ovf = c;
      end
      if (!a_busy && st_busy_fall < 0) st_busy_fall = c;
      ps = a_sck; py = a_sync; pl = a_ldac;
    end
  endtask

  task automatic watch_b(input logic [0:0] ad, input logic [7:0] d, input int ncyc);
    logic ps;
    clear_stats();
    ps = b_sck;
    for (int c = 0; c <= ncyc; c++) begin
      if (c == 0) begin
        b_iocs = 1'b1; b_iowr = 1'b1; b_addr = ad; b_din = d;
      end else begin
        b_iocs = 1'b0; b_iowr = 1'b0;
      end
      tick();
      if (b_sck != ps) st_ntog++;
      if (b_sck && !ps) begin
        if (st_first_rise < 0) st_first_rise = c;
        st_last_rise = c;
        st_nrise++;
        st_word = {st_word[14:0], b_sdo};
      end
      if (b_sync != 1'b1) st_sync_low++;
      if (!b_ldac) st_ldac_low++;
      ps = b_sck;
    end
  endtask

  initial begin
    a_iocs = 1'b0; a_iowr = 1'b0; a_addr = '0; a_din = '0;
    b_iocs = 1'b0; b_iowr = 1'b0; b_addr = '0; b_din = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sck", a_sck, 0);
    chk("rst_sdo", a_sdo, 0);
    chk("rst_sync", a_sync, 4'hF);
    chk("rst_ldac", a_ldac, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_full", a_full, 0);
    chk("rst_ovf", a_ovf, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single word to channel 2.
    wa[0] = 2'd2; wd[0] = 16'hA5C3;
    watch_a(1, 75);
    chk("t1_frames", st_nframe, 1);
    chk("t1_fstart", st_fstart[0], 1);
    chk("t1_fsync", st_fsync[0], 4'b1011);
    chk("t1_sync_low", st_sync_low, 66);
    chk("t1_nrise", st_nrise, 16);
    chk("t1_first_rise", st_first_rise, 3);
    chk("t1_last_rise", st_last_rise, 63);
    chk("t1_word", st_word, 16'hA5C3);
    chk("t1_ldac_first", st_first_ldac, 67);
    chk("t1_ldac_low", st_ldac_low, 2);
    chk("t1_busy_fall", st_busy_fall, 69);
    chk("t1_sck_idle", a_sck, 0);
    chk("t1_sdo_idle", a_sdo, 0);

    // Three queued words to channels 0, 1, 3: one LDAC after the batch.
    wa[0] = 2'd0; wd[0] = 16'h1234;
    wa[1] = 2'd1; wd[1] = 16'hBEEF;
    wa[2] = 2'd3; wd[2] = 16'h0F0F;
    watch_a(3, 215);
    chk("t2_frames", st_nframe, 3);
    chk("t2_fstart0", st_fstart[0], 1);
    chk("t2_fstart1", st_fstart[1], 69);
    chk("t2_fstart2", st_fstart[2], 137);
    chk("t2_fsync0", st_fsync[0], 4'b1110);
    chk("t2_fsync1", st_fsync[1], 4'b1101);
    chk("t2_fsync2", st_fsync[2], 4'b0111);
    chk("t2_sync_low", st_sync_low, 198);
    chk("t2_nrise", st_nrise, 48);
    chk("t2_word_last", st_word, 16'h0F0F);
    chk("t2_nldac", st_nldac, 1);
    chk("t2_ldac_first", st_first_ldac, 203);
    chk("t2_busy_fall", st_busy_fall, 205);

    // DEPTH+2 back-to-back writes: first is popped early, last one overflows.
    for (int i = 0; i < 6; i++) begin
      wa[i] = 2'(i);
      wd[i] = 16'h1001 + 16'(i);
    end
    watch_a(6, 350);
    chk("t3_first_full", st_first_full, 4);
    chk("t3_novf", st_novf, 1);
    chk("t3_first_ovf", st_first_ovf, 5);
    chk("t3_frames", st_nframe, 5);
    chk("t3_nrise", st_nrise, 80);
    chk("t3_word_last", st_word, 16'h1005);
    chk("t3_busy_fall", st_busy_fall, 341);
    chk("t3_full_end", a_full, 0);

    // Reset asserted while bit 7 is high.
    wa[0] = 2'd2; wd[0] = 16'hA5C3;
    watch_a(1, 32);
    chk("t4_pre_nrise", st_nrise, 8);
    chk("t4_pre_sck", a_sck, 1);
    chk("t4_pre_sdo", a_sdo, 1);
    chk("t4_pre_sync", a_sync, 4'b1011);
    rst_n = 1'b0;
    #2;
    chk("t4_sck", a_sck, 0);
    chk("t4_sdo", a_sdo, 0);
    chk("t4_sync", a_sync, 4'hF);
    chk("t4_busy", a_busy, 0);
    chk("t4_ldac", a_ldac, 1);
    chk("t4_full", a_full, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    wa[0] = 2'd0; wd[0] = 16'h0001;
    watch_a(1, 75);
    chk("t4_post_word", st_word, 16'h0001);
    chk("t4_post_nrise", st_nrise, 16);
    chk("t4_post_fsync", st_fsync[0], 4'b1110);
    chk("t4_post_sync_low", st_sync_low, 66);
    chk("t4_post_busy_fall", st_busy_fall, 69);

    // DIV=1, W=8, single channel, no LDAC.
    watch_b(1'b0, 8'h81, 25);
    chk("t5_sync_low", st_sync_low, 17);
    chk("t5_nrise", st_nrise, 8);
    chk("t5_first_rise", st_first_rise, 2);
    chk("t5_last_rise", st_last_rise, 16);
    chk("t5_toggles", st_ntog, 16);
    chk("t5_word", st_word[7:0], 8'h81);
    chk("t5_ldac_low", st_ldac_low, 0);

    // Out-of-range channel: frame is shifted, no sync asserts.
    watch_b(1'b1, 8'h5A, 25);
    chk("t6_nrise", st_nrise, 8);
    chk("t6_first_rise", st_first_rise, 2);
    chk("t6_word", st_word[7:0], 8'h5A);
    chk("t6_sync_low", st_sync_low, 0);
    chk("t6_busy_end", b_busy, 0);
    chk("t6_full_end", b_full, 0);
    chk("t6_ovf_end", b_ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
